// File: rtl/hamming_scheduler_if.sv
// Request/response bundle between two requesters, the shared Hamming(7,4)
// scheduler and the downstream response consumer.
interface hamming_scheduler_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_mode;
  logic [13:0] req_payload;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_mode;
  logic [6:0]  rsp_data;
  logic [2:0]  rsp_syndrome;
  logic        rsp_corrected;

  modport master (
    output req_valid, req_mode, req_payload, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_mode, rsp_data, rsp_syndrome, rsp_corrected
  );

  modport slave (
    input  req_valid, req_mode, req_payload, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_mode, rsp_data, rsp_syndrome, rsp_corrected
  );
endinterface

// File: rtl/hamming_scheduler.sv
// Round-robin scheduler sharing one Hamming(7,4) encode/decode codec between
// two requesters, with a one-entry registered response slot and error counter.
module hamming_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  hamming_scheduler_if.slave  bus,
  input  logic                clear_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Codeword layout: code[0..6] = p1, p2, d0, p4, d1, d2, d3.
  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

  function automatic logic [2:0] hamming_syndrome(input logic [6:0] c);
    logic [2:0] s;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    return s;
  endfunction

  // A nonzero syndrome names the 1-based bit position to flip.
  function automatic logic [3:0] hamming_correct(input logic [6:0] c, input logic [2:0] s);
    logic [6:0] fixed;
    fixed = c;
    if (s != 3'd0) begin
      fixed[s - 3'd1] = ~c[s - 3'd1];
    end else begin
      fixed = c;
    end
    return {fixed[6], fixed[5], fixed[4], fixed[2]};
  endfunction

  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic             rsp_mode_r;
  logic [6:0]       rsp_data_r;
  logic [2:0]       rsp_syndrome_r;
  logic             rsp_corrected_r;
  logic             last_r;
  logic [CNT_W-1:0] err_count_r;

  logic             slot_free_s;
  logic [1:0]       grant_s;
  logic             grant_any_s;
  logic             grant_id_s;
  logic             sel_mode_s;
  logic [6:0]       sel_payload_s;
  logic [2:0]       raw_syndrome_s;
  logic [6:0]       res_data_s;
  logic [2:0]       res_syndrome_s;
  logic             res_corrected_s;

  // Arbitration: grant only when the slot can take a result; alternate on conflict.
  always_comb begin
    slot_free_s = 1'b0;
    grant_s     = 2'b00;
    if (rst_n) begin
      slot_free_s = !rsp_valid_r || bus.rsp_ready;
    end else begin
      slot_free_s = 1'b0;
    end
    if (slot_free_s) begin
      case (bus.req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign grant_any_s = |grant_s;
  assign grant_id_s  = grant_s[1];

  // Codec datapath on the granted requester's job.
  always_comb begin
    sel_mode_s      = bus.req_mode[grant_id_s];
    sel_payload_s   = grant_id_s ? bus.req_payload[13:7] : bus.req_payload[6:0];
    raw_syndrome_s  = hamming_syndrome(sel_payload_s);
    res_data_s      = 7'd0;
    res_syndrome_s  = 3'd0;
    res_corrected_s = 1'b0;
    if (sel_mode_s) begin
      res_data_s      = {3'b000, hamming_correct(sel_payload_s, raw_syndrome_s)};
      res_syndrome_s  = raw_syndrome_s;
      res_corrected_s = (raw_syndrome_s != 3'd0);
    end else begin
      res_data_s      = hamming_encode(sel_payload_s[3:0]);
      res_syndrome_s  = 3'd0;
      res_corrected_s = 1'b0;
    end
  end

  // Response slot: load on grant, empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r     <= 1'b0;
      rsp_id_r        <= 1'b0;
      rsp_mode_r      <= 1'b0;
      rsp_data_r      <= 7'd0;
      rsp_syndrome_r  <= 3'd0;
      rsp_corrected_r <= 1'b0;
    end else if (grant_any_s) begin
      rsp_valid_r     <= 1'b1;
      rsp_id_r        <= grant_id_s;
      rsp_mode_r      <= sel_mode_s;
      rsp_data_r      <= res_data_s;
      rsp_syndrome_r  <= res_syndrome_s;
      rsp_corrected_r <= res_corrected_s;
    end else if (bus.rsp_ready) begin
      rsp_valid_r     <= 1'b0;
    end
  end

  // Round-robin pointer; reset to 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (grant_any_s) begin
      last_r <= grant_id_s;
    end
  end

  // Saturating corrected-word counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= {CNT_W{1'b0}};
    end else if (clear_count) begin
      err_count_r <= {CNT_W{1'b0}};
    end else if (grant_any_s && res_corrected_s && (err_count_r != CNT_MAX)) begin
      err_count_r <= err_count_r + CNT_W'(1);
    end
  end

  assign bus.req_ready     = grant_s;
  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_id        = rsp_id_r;
  assign bus.rsp_mode      = rsp_mode_r;
  assign bus.rsp_data      = rsp_data_r;
  assign bus.rsp_syndrome  = rsp_syndrome_r;
  assign bus.rsp_corrected = rsp_corrected_r;
  assign err_count         = err_count_r;

endmodule
